tdc_hit_encoder: RTL and testbench
==================================

// Module: tdc_hit_encoder
// PURPOSE
//   Consumes the 33-tap thermometer snapshot produced each clk by the TDC tap-latch shift stage.
//   Detects hit leading edges and encodes the fine time as the popcount of the taps.
//   Stamps each hit with a free-running coarse counter value.
//   Buffers events in a FIFO and drains them through a valid/ready port to the readout logic.
// PARAMETERS
//   NTAPS       33   width of the tap snapshot (fine-time resolution)
//   FINE_W      6    fine-time width; must satisfy 2**FINE_W > NTAPS
//   COARSE_W    16   coarse counter width
//   FIFO_DEPTH  16   event FIFO depth, power of 2, >= 2
// PORTS
//   clk       in   1                  single clock; all logic on rising edge
//   rst       in   1                  synchronous reset, active-high
//   en        in   1                  hit detection enable
//   taps      in   NTAPS              tap snapshot from the shift stage (bit 0 = first tap)
//   ev_data   out  COARSE_W+FINE_W    event word {coarse, fine}; valid when ev_valid
//   ev_valid  out  1                  FIFO not empty
//   ev_ready  in   1                  consumer accepts; pop on ev_valid & ev_ready
//   fifo_full out  1                  FIFO holds FIFO_DEPTH entries
//   ovf_cnt   out  8                  dropped-event count, saturates at 255
//   clr_ovf   in   1                  synchronous clear of ovf_cnt
// BEHAVIOUR
//   Reset:
//   - On rst, all of the following go to 0: coarse counter, pipeline valids, FIFO pointers, ev_data,
//     ev_valid, fifo_full and ovf_cnt.
//   - The prev_tap0 history bit is set to 1, so taps held high through reset produce no hit.
//   - Reset mid-operation discards all in-flight and stored events.
//   Coarse counter:
//   - Increments every clk from 0 and wraps from 2**COARSE_W-1 to 0.
//   - It is independent of en.
//   S1 (edge t):
//   - taps_q <= taps.
//   - coarse_q <= the coarse counter value before its increment at edge t.
//   S2 (edge t+1):
//   - hit = en & taps_q[0] & ~prev_tap0.
//   - prev_tap0 <= en ? taps_q[0] : 1.
//   - If hit: fine <= popcount(taps_q), range 0..NTAPS, FINE_W bits, no bubble correction;
//     coarse is carried alongside.
//   - The timestamp is the S1 sample, not the S2 cycle.
//   S3 (edge t+2):
//   - A valid S2 event is written to the FIFO.
//   - If the FIFO was empty, ev_valid=1 and ev_data=event after edge t+2, i.e. 3 edges after the
//     taps were presented.
//   Hit rules:
//   - Only the 0->1 edge of tap0 counts. A tap0 held high for N cycles gives exactly 1 event.
//   - A new hit requires tap0 to go low for at least one enabled sample.
//   - en=0 forces prev_tap0=1, so enabling while tap0 is high gives no false hit.
//   - Events already in S2/S3 when en falls are still written.
//   FIFO:
//   - First-word fall-through: ev_data is the head entry, and it is held stable while
//     ev_valid & ~ev_ready.
//   - Pop on ev_valid & ev_ready.
//   - Write when full without a pop: the event is dropped, FIFO contents are unchanged, and
//     ovf_cnt increments (saturating at 255).
//   - Write when full with a pop in the same cycle: the write is accepted, no drop, and the
//     FIFO stays full.
//   - Write and pop when empty: not possible, since ev_valid=0.
//   - fifo_full and ev_valid are derived from the registered pointers, with no combinational path
//     from ev_ready.
//   ovf_cnt:
//   - clr_ovf has priority: a clear and a drop in the same cycle leave ovf_cnt=0.
//   - Saturates at 255; it does not wrap.
// TESTING
//   Reset: assert rst for 2 cycles with taps all ones -> all outputs 0, no event after release
//     while taps stay high.
//   Single hit: en=1, taps=0 then 33'h0_0000_00FF captured when coarse=16'h0010 ->
//     ev_data={16'h0010,6'd8}, ev_valid rises 3 edges later.
//   Held pulse: taps=33'h1_FFFF_FFFF for 5 cycles then 0 -> exactly one event with fine=33.
//     The next 0->1 edge gives a second event.
//   Coarse wrap: hits at coarse 16'hFFFF and 16'h0001 -> events read in order with coarse
//     FFFF then 0001.
//   Overflow: ev_ready=0, 17 isolated hits -> fifo_full=1, 16 events stored, ovf_cnt=1.
//     A hit coincident with a pop while full is accepted, with ovf_cnt unchanged.
//     Set clr_ovf -> ovf_cnt=0.
//   Enable/reset: raise en while tap0=1 -> no event. Assert rst with 3 events queued ->
//     ev_valid=0 next cycle and the queued events are never output.

Source files
------------

// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder
//   Turns the per-cycle TDC thermometer snapshot into timestamped hit events.
//   A hit is a 0->1 edge on tap0. Its fine time is the popcount of the snapshot,
//   and its coarse time is the free-running counter value at capture.
//   Events are queued in a first-word fall-through FIFO and drained to readout.
//
//   Handshake: ev_valid means the FIFO is not empty, and ev_data is then the
//   head entry. A word transfers on any rising edge where ev_valid & ev_ready.
//   ev_data stays stable while ev_valid & ~ev_ready. ev_valid and fifo_full
//   depend only on registered pointers, never combinationally on ev_ready.
module tdc_hit_encoder #(
  parameter int NTAPS      = 33,
  parameter int FINE_W     = 6,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NTAPS-1:0]             taps,
  output logic [COARSE_W+FINE_W-1:0]   ev_data,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic                         fifo_full,
  output logic [7:0]                   ovf_cnt,
  input  logic                         clr_ovf
);

  localparam int EW = COARSE_W + FINE_W;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [COARSE_W-1:0] coarse_cnt;
  logic [COARSE_W-1:0] coarse_q;
  logic [NTAPS-1:0]    taps_q;
  logic                s1_valid;
  logic                prev_tap0;
  logic                s2_valid;
  logic [EW-1:0]       s2_data;
  logic [FINE_W-1:0]   tap_count;
  logic                hit;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;
  logic                empty;
  logic                pop;
  logic                push;
  logic                drop;

  // Free-running coarse time base, unaffected by en.
  always_ff @(posedge clk) begin
    if (rst) coarse_cnt <= '0;
    else     coarse_cnt <= coarse_cnt + COARSE_W'(1);
  end

  // S1: register the snapshot with the coarse value current at that edge.
  // s1_valid keeps stale taps_q from being judged right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q   <= '0;
      coarse_q <= '0;
      s1_valid <= 1'b0;
    end else begin
      taps_q   <= taps;
      coarse_q <= coarse_cnt;
      s1_valid <= 1'b1;
    end
  end

  // Fine time: plain popcount of the snapshot, no bubble correction.
  always_comb begin
    tap_count = '0;
    for (int i = 0; i < NTAPS; i++) begin
      tap_count = tap_count + FINE_W'(taps_q[i]);
    end
  end

  assign hit = s1_valid & en & taps_q[0] & ~prev_tap0;

  // S2: leading-edge detect on tap0. Disabling forces the history high so
  // that re-enabling during a high tap0 cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_tap0 <= 1'b1;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
    end else begin
      s2_valid <= hit;
      if (hit) s2_data <= {coarse_q, tap_count};
      if (s1_valid) prev_tap0 <= en ? taps_q[0] : 1'b1;
    end
  end

  // FIFO status from registered pointers only; the extra MSB separates full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign ev_valid  = ~empty;
  assign ev_data   = ev_valid ? mem[rd_ptr[PW-1:0]] : '0;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
  assign pop  = ev_valid & ev_ready;
  assign push = s2_valid & (~fifo_full | pop);
  assign drop = s2_valid & fifo_full & ~pop;

  // S3: event storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr[PW-1:0]] <= s2_data;
  end

  // FIFO pointers; reset empties the queue and discards stored events.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Dropped-event counter: clear wins over a same-cycle drop, saturates at 255.
  always_ff @(posedge clk) begin
    if (rst)                          ovf_cnt <= '0;
    else if (clr_ovf)                 ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Bench for tdc_hit_encoder: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a queue-based event model.
module tb_tdc_hit_encoder;

  localparam int NTAPS = 33;
  localparam int EW    = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NTAPS-1:0]  taps;
  logic [EW-1:0]     ev_data;
  logic              ev_valid;
  logic              ev_ready;
  logic              fifo_full;
  logic [7:0]        ovf_cnt;
  logic              clr_ovf;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tdc_hit_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .taps     (taps),
    .ev_data  (ev_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .fifo_full(fifo_full),
    .ovf_cnt  (ovf_cnt),
    .clr_ovf  (clr_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Events are stamped with the coarse count at the sampling edge, judged one
  // edge later against the previous enabled tap0, and enter the queue the edge after.
  logic [EW-1:0]    exp_q[$];
  logic [15:0]      m_cnt;
  logic [15:0]      m_c1;
  logic [NTAPS-1:0] m_t1;
  bit               m_s1v, m_s2v, m_prev, m_live;
  logic [EW-1:0]    m_s2d;
  int               m_ovf;

  initial m_live = 1'b0;

  always @(posedge clk) begin
    bit m_pop, m_full, m_drop;
    if (rst) begin
      exp_q.delete();
      m_cnt = 16'd0; m_s1v = 0; m_s2v = 0; m_prev = 1; m_ovf = 0; m_live = 1;
    end else begin
      m_pop  = (exp_q.size() != 0) && ev_ready;
      m_full = (exp_q.size() == 16);
      if (m_pop) exp_q.delete(0);
      m_drop = 0;
      if (m_s2v) begin
        if (!m_full || m_pop) exp_q.push_back(m_s2d);
        else m_drop = 1;
      end
      if (clr_ovf) m_ovf = 0;
      else if (m_drop && m_ovf < 255) m_ovf = m_ovf + 1;
      if (m_s1v) begin
        m_s2v  = en && m_t1[0] && !m_prev;
        m_s2d  = {m_c1, 6'($countones(m_t1))};
        m_prev = en ? m_t1[0] : 1'b1;
      end else begin
        m_s2v = 0;
      end
      m_t1  = taps;
      m_c1  = m_cnt;
      m_s1v = 1;
      m_cnt = m_cnt + 16'd1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("ev_valid",  32'(ev_valid),  32'(exp_q.size() != 0));
      check("ev_data",   32'(ev_data),   (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("fifo_full", 32'(fifo_full), 32'(exp_q.size() == 16));
      check("ovf_cnt",   32'(ovf_cnt),   32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until the next rising edge will capture coarse value target.
  task automatic wait_cnt(input logic [15:0] target);
    int n = 0;
    while (m_cnt != target && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("wait_cnt_timeout", 32'(m_cnt), 32'(target));
  endtask

  task automatic pulse_hit(input logic [NTAPS-1:0] t);
    taps = t;
    @(negedge clk);
    taps = '0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b1; taps = '1; ev_ready = 1'b0; clr_ovf = 1'b0;

    // Reset held 2 cycles with all taps high.
    cycles(2);
    check("rst_ev_valid",  32'(ev_valid), 32'd0);
    check("rst_ev_data",   32'(ev_data),  32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_ovf_cnt",   32'(ovf_cnt),  32'd0);
    rst = 1'b0;
    cycles(8);
    check("rst_taps_high_no_event", 32'(ev_valid), 32'd0);

    // Single hit captured at coarse 0x0010.
    taps = '0;
    wait_cnt(16'h0010);
    taps = 33'h0_0000_00FF;
    @(negedge clk);
    taps = '0;
    @(negedge clk);
    check("single_not_yet", 32'(ev_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(ev_valid), 32'd1);
    check("single_data",  32'(ev_data),  32'({16'h0010, 6'd8}));
    pop_one();
    check("single_drained", 32'(ev_valid), 32'd0);

    // Held pulse: one event only, then a new edge gives another.
    taps = 33'h1_FFFF_FFFF;
    cycles(5);
    taps = '0;
    cycles(4);
    check("held_valid", 32'(ev_valid), 32'd1);
    check("held_fine",  32'(ev_data[5:0]), 32'd33);
    pop_one();
    cycles(3);
    check("held_one_event", 32'(ev_valid), 32'd0);
    pulse_hit(33'h1);
    cycles(2);
    check("held_second_valid", 32'(ev_valid), 32'd1);
    check("held_second_fine",  32'(ev_data[5:0]), 32'd1);
    pop_one();

    // Enabling while tap0 is high must not create a hit.
    en = 1'b0;
    taps = 33'h3;
    cycles(3);
    en = 1'b1;
    cycles(6);
    check("enable_high_no_event", 32'(ev_valid), 32'd0);
    taps = '0;
    cycles(3);

    // Reset with three queued events discards them.
    for (int i = 0; i < 3; i++) pulse_hit(33'h1);
    cycles(3);
    check("queued_before_rst", 32'(ev_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_flush_valid", 32'(ev_valid), 32'd0);
    check("rst_flush_data",  32'(ev_data),  32'd0);
    rst = 1'b0;
    cycles(5);
    check("rst_flush_stays_empty", 32'(ev_valid), 32'd0);

    // Overflow: 17 isolated hits with no readout.
    for (int i = 0; i < 17; i++) pulse_hit(33'h1);
    cycles(4);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_cnt_1", 32'(ovf_cnt), 32'd1);
    // Hit arriving in the same cycle as a pop while full is accepted.
    taps = 33'h1;
    @(negedge clk);
    taps = '0;
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("ovf_pop_write_full", 32'(fifo_full), 32'd1);
    check("ovf_pop_write_cnt",  32'(ovf_cnt),   32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf_cnt), 32'd0);
    ev_ready = 1'b1;
    cycles(20);
    ev_ready = 1'b0;
    check("ovf_drained", 32'(ev_valid), 32'd0);

    // Coarse wrap: hits at 0xFFFF and 0x0001.
    wait_cnt(16'hFFFF);
    taps = 33'h1;
    @(negedge clk);
    taps = '0;
    @(negedge clk);
    taps = 33'h1;
    @(negedge clk);
    taps = '0;
    cycles(4);
    check("wrap_first",  32'(ev_data), 32'({16'hFFFF, 6'd1}));
    pop_one();
    check("wrap_second", 32'(ev_data), 32'({16'h0001, 6'd1}));
    pop_one();
    check("wrap_drained", 32'(ev_valid), 32'd0);

    // Randomized traffic with phases of differing readout pressure.
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 500; c++) begin
        logic t0;
        t0 = taps[0];
        if ($urandom_range(0, 9) < 3) t0 = ~t0;
        taps     = {$urandom_range(0, 1) == 1, $urandom(), 1'b0};
        taps[0]  = t0;
        en       = ($urandom_range(0, 9) != 0);
        ev_ready = (p % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        clr_ovf  = ($urandom_range(0, 99) == 0);
        rst      = ($urandom_range(0, 799) == 0);
        @(negedge clk);
      end
    end
    rst = 1'b0; clr_ovf = 1'b0; ev_ready = 1'b1; taps = '0;
    cycles(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
